serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Parametrised serial frame transmitter for the Morse/serial link datapath. It accepts a parallel word over a ready/load handshake and serialises it through an internal shift register. Each frame is a start bit, DATA_W data bits in a selectable order, an optional parity bit and STOP_BITS stop bits, with every bit held for BIT_CYCLES clocks. It sits between the word source and the line driver and replaces the fixed 8-bit transmitter.

## Interface
- DATA_W, 8, data bits per frame (1–32)
- BIT_CYCLES, 4, clocks per serial bit (≥1)
- STOP_BITS, 1, stop bits per frame (1 or 2)
- MSB_FIRST, 0, 0 = LSB shifted out first (shift right); 1 = MSB first (shift left)
- PARITY_ODD, 0, 0 = even parity; 1 = odd parity (used only with TX_PARITY_EN)
- CLK  input  1  sole clock; all logic on rising edge
- RST  input  1  reset, synchronous, active-high
- data_in  input  DATA_W  word to transmit; sampled only on an accepted load
- load  input  1  request to transmit data_in
- ready  output  1  block can accept a load this cycle
- tx_out  output  1  serial line; idles high
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse when a frame's last stop bit completes

## Operation
- One clock domain: CLK. RST is synchronous and active-high.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, ready=1, busy=0. Load is accepted when load && ready. On acceptance:
  - the shift register is loaded with data_in;
  - the parity bit is computed from data_in and registered (XOR-reduce, then XOR PARITY_ODD);
  - the state moves to START.
- START: tx_out=0 for BIT_CYCLES clocks, then DATA.
- DATA: tx_out is the register's LSB (MSB_FIRST=0) or MSB (MSB_FIRST=1). The register shifts every BIT_CYCLES clocks, and a bit index counts 0..DATA_W-1. After DATA_W bits the state goes to PARITY if parity is compiled in, otherwise to STOP.
- PARITY: tx_out = registered parity bit for BIT_CYCLES clocks, then STOP.
- STOP: tx_out=1 for STOP_BITS×BIT_CYCLES clocks, then IDLE with done=1 for exactly that first IDLE cycle.
- Counters:
  - cycle counter is $clog2(BIT_CYCLES) bits wide, minimum 1;
  - bit counter is $clog2(DATA_W+1) bits wide;
  - both wrap to 0 on bit boundaries, with no overflow beyond the terminal count.
- load while busy (ready=0): ignored, not queued. data_in changes mid-frame have no effect.
- Back-to-back: load in the done cycle is accepted, and the next START follows with no idle bit.
- RST at any point, including mid-frame: next cycle state=IDLE, tx_out=1, ready=1, busy=0, done=0, counters and shift register cleared. A load in the same cycle as RST is dropped.

## Timing
- Reset values: tx_out=1, ready=1, busy=0, done=0.
- All outputs are registered.
- Load accepted at edge n: tx_out=0 and busy=1 from edge n+1, ready=0 from edge n+1.
- Frame length F = (1 + DATA_W + P + STOP_BITS) × BIT_CYCLES clocks, where P=1 if TX_PARITY_EN is defined, else 0.
- done is high for the cycle starting at edge n+1+F, and ready=1 and busy=0 in that same cycle.
- Maximum throughput: one frame per F clocks.

## Configuration
- TX_PARITY_EN defined: the PARITY state, parity register and PARITY_ODD handling are compiled in, and the frame carries one parity bit after the data.
- TX_PARITY_EN undefined: no parity logic. DATA goes directly to STOP, P=0, and PARITY_ODD is unused.

## Test plan
- Reset: hold RST 3 cycles with load=1 -> tx_out=1, ready=1, busy=0, done=0 throughout; no frame starts.
- LSB-first frame, parity on: DATA_W=8, BIT_CYCLES=4, even parity, load 8'hA5.
  - tx_out per 4-clock bit = 0, 1,0,1,0,0,1,0,1, 0, 1;
  - done pulses 44 cycles after acceptance.
- MSB-first, odd parity: MSB_FIRST=1, PARITY_ODD=1, load 8'h01.
  - data bits 0,0,0,0,0,0,0,1;
  - parity bit 0;
  - with TX_PARITY_EN undefined, the frame is 40 cycles with no parity bit.
- Back-to-back and load-while-busy:
  - load 8'h3C, then pulse load with 8'hFF mid-frame -> the pulse is ignored;
  - load 8'hC3 in the done cycle -> its start bit begins the next cycle with no idle gap.
- Mid-frame reset: assert RST during the 3rd data bit of 8'hA5 -> next cycle tx_out=1, busy=0; a fresh load of 8'h5A transmits a complete, correct frame.
- Parameter sweep: DATA_W=5, BIT_CYCLES=1, STOP_BITS=2, load 5'h1F -> 0,1,1,1,1,1,(parity),1,1 at one bit per clock; done follows at the expected F.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits (LSB- or MSB-first), optional parity, stop bits.
// Define TX_PARITY_EN to compile in the parity bit (PARITY_ODD selects odd parity).
module serial_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     cyc_cnt_r;
    logic [BW-1:0]     bit_cnt_r;
    logic [DATA_W-1:0] shreg_r;
    logic [DATA_W-1:0] shreg_next_s;
`ifdef TX_PARITY_EN
    logic              parity_r;

    function automatic logic frame_parity(input logic [DATA_W-1:0] v);
        return (^v) ^ PARITY_ODD[0];
    endfunction
`endif

    // The bit that currently sits at the line end of the shift register.
    function automatic logic line_bit(input logic [DATA_W-1:0] v);
        if (MSB_FIRST != 0) begin
            return v[DATA_W-1];
        end else begin
            return v[0];
        end
    endfunction

    // Shift register contents after one bit has been sent.
    always_comb begin
        shreg_next_s = shreg_r;
        if (MSB_FIRST != 0) begin
            shreg_next_s = shreg_r << 1;
        end else begin
            shreg_next_s = shreg_r >> 1;
        end
    end

    // Frame sequencer; outputs are registered and reflect the state entered at each edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            cyc_cnt_r <= '0;
            bit_cnt_r <= '0;
            shreg_r   <= '0;
            tx_out    <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load && ready) begin
                        shreg_r   <= data_in;
`ifdef TX_PARITY_EN
                        parity_r  <= frame_parity(data_in);
`endif
                        cyc_cnt_r <= '0;
                        bit_cnt_r <= '0;
                        state_r   <= START;
                        tx_out    <= 1'b0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        tx_out <= 1'b1;
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                START: begin
                    if (cyc_cnt_r == CYC_LAST) begin
                        cyc_cnt_r <= '0;
                        state_r   <= DATA;
                        tx_out    <= line_bit(shreg_r);
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 1'b1;
                    end
                end
                DATA: begin
                    if (cyc_cnt_r == CYC_LAST) begin
                        cyc_cnt_r <= '0;
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_r <= '0;
`ifdef TX_PARITY_EN
                            state_r   <= PARITY;
                            tx_out    <= parity_r;
`else
                            state_r   <= STOP;
                            tx_out    <= 1'b1;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                            shreg_r   <= shreg_next_s;
                            tx_out    <= line_bit(shreg_next_s);
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 1'b1;
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    if (cyc_cnt_r == CYC_LAST) begin
                        cyc_cnt_r <= '0;
                        state_r   <= STOP;
                        tx_out    <= 1'b1;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // bit_cnt_r is reused here to count stop bits.
                    if (cyc_cnt_r == CYC_LAST) begin
                        cyc_cnt_r <= '0;
                        if (bit_cnt_r == STOP_LAST) begin
                            bit_cnt_r <= '0;
                            state_r   <= IDLE;
                            tx_out    <= 1'b1;
                            ready     <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cyc_cnt_r <= '0;
                    bit_cnt_r <= '0;
                    tx_out    <= 1'b1;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: two configurations, a per-cycle line model and random traffic.
module tb_serial_frame_tx;

    localparam int DW [2] = '{8, 5};
    localparam int BC [2] = '{4, 1};
    localparam int SB [2] = '{1, 2};
    localparam int MF [2] = '{0, 1};
    localparam int PO [2] = '{0, 1};
`ifdef TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F0 = (1 + 8 + P + 1) * 4;
    localparam int F1 = (1 + 5 + P + 2) * 1;

    typedef struct packed {
        logic tx;
        logic ready;
        logic busy;
        logic done;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din0;
    logic [4:0] din1;
    logic       ld   [2];
    logic       rdy  [2];
    logic       txo  [2];
    logic       bsy  [2];
    logic       dn   [2];

    bit   line     [2][$];
    obs_t expq     [2][$];
    bit   m_ready  [2] = '{1'b1, 1'b1};
    bit   m_busy   [2] = '{1'b0, 1'b0};
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   seen_done;

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .STOP_BITS(1), .MSB_FIRST(0), .PARITY_ODD(0)) dut0 (
        .CLK(clk), .RST(rst), .data_in(din0), .load(ld[0]),
        .ready(rdy[0]), .tx_out(txo[0]), .busy(bsy[0]), .done(dn[0])
    );

    serial_frame_tx #(.DATA_W(5), .BIT_CYCLES(1), .STOP_BITS(2), .MSB_FIRST(1), .PARITY_ODD(1)) dut1 (
        .CLK(clk), .RST(rst), .data_in(din1), .load(ld[1]),
        .ready(rdy[1]), .tx_out(txo[1]), .busy(bsy[1]), .done(dn[1])
    );

    // Expected line level for every clock of one frame, built straight from the frame format.
    function automatic void build_frame(input int k, input logic [31:0] d);
        int ones;
        int idx;
        bit b;
        ones = 0;
        repeat (BC[k]) line[k].push_back(1'b0);
        for (int i = 0; i < DW[k]; i++) begin
            idx = (MF[k] != 0) ? (DW[k] - 1 - i) : i;
            b = d[idx];
            if (b) ones++;
            repeat (BC[k]) line[k].push_back(b);
        end
`ifdef TX_PARITY_EN
        b = ((ones % 2) == 1) ^ (PO[k] == 1);
        repeat (BC[k]) line[k].push_back(b);
`endif
        repeat (SB[k] * BC[k]) line[k].push_back(1'b1);
    endfunction

    // Reference model: predicts the outputs that follow each rising edge and queues them.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            obs_t e;
            if (rst) begin
                line[k].delete();
                e = '{tx: 1'b1, ready: 1'b1, busy: 1'b0, done: 1'b0};
            end else begin
                if (m_ready[k] && ld[k]) begin
                    build_frame(k, (k == 0) ? {24'd0, din0} : {27'd0, din1});
                end
                if (line[k].size() > 0) begin
                    e = '{tx: line[k].pop_front(), ready: 1'b0, busy: 1'b1, done: 1'b0};
                end else begin
                    e = '{tx: 1'b1, ready: 1'b1, busy: 1'b0, done: m_busy[k]};
                end
            end
            m_ready[k] = e.ready;
            m_busy[k]  = e.busy;
            expq[k].push_back(e);
        end
    end

    // Monitor: pops one prediction per DUT per cycle and compares mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            obs_t e;
            obs_t got;
            if (expq[k].size() > 0) begin
                e   = expq[k].pop_front();
                got = '{tx: txo[k], ready: rdy[k], busy: bsy[k], done: dn[k]};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL dut%0d outputs @%0t: tx/ready/busy/done got %b required %b",
                             k, $time, got, e);
                end
            end
        end
    end

    task automatic drive_load(input int k, input logic [31:0] d);
        if (k == 0) din0 = d[7:0];
        else        din1 = d[4:0];
        ld[k] = 1'b1;
        @(negedge clk);
        ld[k] = 1'b0;
        din0 = 8'($urandom);
        din1 = 5'($urandom);
    endtask

    initial begin
        rst   = 1'b1;
        ld[0] = 1'b1;
        ld[1] = 1'b1;
        din0  = 8'hA5;
        din1  = 5'h1F;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (txo[k] !== 1'b1 || rdy[k] !== 1'b1 || bsy[k] !== 1'b0 || dn[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dut%0d reset state @%0t: tx=%b ready=%b busy=%b done=%b required 1 1 0 0",
                             k, $time, txo[k], rdy[k], bsy[k], dn[k]);
                end
            end
        end
        rst   = 1'b0;
        ld[0] = 1'b0;
        ld[1] = 1'b0;
        @(negedge clk);

        // First frames on both configurations at once.
        din1  = 5'h1F;
        ld[1] = 1'b1;
        drive_load(0, 32'hA5);
        ld[1] = 1'b0;
        seen_done = 1'b0;
        for (int w = 0; w < F0 + 4; w++) begin
            @(negedge clk);
            if (dn[0] === 1'b1) seen_done = 1'b1;
        end
        n_tests++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL dut0 timeout @%0t: no done within %0d cycles of the first frame", $time, F0 + 4);
        end

        drive_load(0, 32'h01);
        drive_load(1, 32'h01);
        repeat (F0 + 4) @(negedge clk);

        // Load ignored mid-frame, then a new load in the done cycle.
        drive_load(0, 32'h3C);
        repeat (10) @(negedge clk);
        drive_load(0, 32'hFF);
        repeat (F0 - 11) @(negedge clk);
        drive_load(0, 32'hC3);
        repeat (F0 + 4) @(negedge clk);

        // Reset during the third data bit, then a clean frame.
        drive_load(0, 32'hA5);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_load(0, 32'h5A);
        repeat (F0 + 4) @(negedge clk);

        // Random traffic, including loads while busy and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            ld[0] = ($urandom_range(0, 5) == 0);
            ld[1] = ($urandom_range(0, 3) == 0);
            din0  = 8'($urandom);
            din1  = 5'($urandom);
            rst   = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        ld[0] = 1'b0;
        ld[1] = 1'b0;
        rst   = 1'b0;
        repeat (F0 + 10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
